// File: rtl/i2s_stereo_fifo.sv
// i2s_stereo_fifo: stereo frame FIFO between the I2S 24-bit capture block and
// the DSP/beamforming consumer. First-word-fall-through, drop-newest on
// overflow with a sticky flag and a saturating dropped-frame counter.
// Optional macro AUDIO_FIFO_WATERMARK_EN enables the registered level_hi_o
// comparator; without it level_hi_o is tied low.
//
// Handshake: the output side is a strict valid/ready stream. A frame transfers
// on a clock edge where out_valid_o and out_ready_i are both high; out_valid_o
// never depends combinationally on out_ready_i or in_valid_i, and the head data
// is held stable while out_valid_o=1 and out_ready_i=0. The input side has no
// backpressure: in_valid_i is a strobe and a frame that cannot be stored is
// dropped and counted.
module i2s_stereo_fifo #(
  parameter int DEPTH      = 16,
  parameter int DROP_CNT_W = 16,
  parameter int WATERMARK  = 12
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       in_valid_i,
  input  logic [23:0]                in_left_i,
  input  logic [23:0]                in_right_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [23:0]                out_left_o,
  output logic [23:0]                out_right_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       overflow_o,
  output logic [DROP_CNT_W-1:0]      drop_cnt_o,
  input  logic                       clear_ovf_i,
  output logic                       level_hi_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [47:0]           mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         level_q, level_d;
  logic                  out_valid_q, out_valid_d;
  logic [47:0]           out_data_q, out_data_d;
  logic                  overflow_q, overflow_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic                  full, wr, rd, drop;

  // Accept/drop decisions and next-state for pointers, head data and overflow.
  always_comb begin
    full        = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    rd          = out_valid_q & out_ready_i;
    wr          = in_valid_i & (~full | rd);
    drop        = in_valid_i & full & ~rd;
    wr_ptr_d    = wr ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d    = rd ? rd_ptr_q + PW'(1) : rd_ptr_q;
    level_d     = wr_ptr_d - rd_ptr_d;
    out_valid_d = (wr_ptr_d != rd_ptr_d);
    // The head slot may be written this very cycle (FIFO empty after this
    // edge); forward the incoming frame so the head is correct at latency 1.
    if (wr && (rd_ptr_d[AW-1:0] == wr_ptr_q[AW-1:0])) begin
      out_data_d = {in_left_i, in_right_i};
    end else begin
      out_data_d = mem_q[rd_ptr_d[AW-1:0]];
    end
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (clear_ovf_i) begin
        drop_cnt_d = DROP_CNT_W'(1);
      end else if (~&drop_cnt_q) begin
        drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
      end
    end else if (clear_ovf_i) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  // Frame storage; contents are don't-care after reset so no reset here.
  always_ff @(posedge clk_i) begin
    if (wr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {in_left_i, in_right_i};
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

`ifdef AUDIO_FIFO_WATERMARK_EN
  logic level_hi_q, level_hi_d;

  // Watermark flag tracks the next level so it lines up with level_o.
  always_comb begin
    level_hi_d = (level_d >= PW'(WATERMARK));
  end

  // Registered watermark flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_hi_q <= 1'b0;
    end else begin
      level_hi_q <= level_hi_d;
    end
  end

  assign level_hi_o = level_hi_q;
`else
  assign level_hi_o = 1'b0;
`endif

  assign out_valid_o = out_valid_q;
  assign out_left_o  = out_data_q[47:24];
  assign out_right_o = out_data_q[23:0];
  assign level_o     = level_q;
  assign overflow_o  = overflow_q;
  assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_i2s_stereo_fifo.sv
// Self-checking bench for i2s_stereo_fifo (DEPTH=16, WATERMARK=12).
module tb_i2s_stereo_fifo;

  localparam int DEPTH = 16;
  localparam int DW    = 16;
  localparam int WM    = 12;
`ifdef AUDIO_FIFO_WATERMARK_EN
  localparam bit WM_EN = 1'b1;
`else
  localparam bit WM_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i = 1'b1;
  logic          in_valid_i = 1'b0;
  logic [23:0]   in_left_i = '0, in_right_i = '0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic [23:0]   out_left_o, out_right_o;
  logic [4:0]    level_o;
  logic          overflow_o;
  logic [DW-1:0] drop_cnt_o;
  logic          clear_ovf_i = 1'b0;
  logic          level_hi_o;

  i2s_stereo_fifo #(.DEPTH(DEPTH), .DROP_CNT_W(DW), .WATERMARK(WM)) dut (
    .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_left_i(in_left_i),
    .in_right_i(in_right_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_left_o(out_left_o), .out_right_o(out_right_o), .level_o(level_o),
    .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o), .clear_ovf_i(clear_ovf_i),
    .level_hi_o(level_hi_o)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [47:0] exp_q[$];
  bit          mdl_ovf  = 1'b0;
  int          mdl_drop = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock of stimulus; the reference queue is updated and all outputs
  // are compared against it #1 after the edge.
  task automatic step(input bit v, input logic [23:0] l, input logic [23:0] r,
                      input bit rdy, input bit clr, input bit rs);
    bit rd, full, drop;
    @(negedge clk);
    in_valid_i = v; in_left_i = l; in_right_i = r;
    out_ready_i = rdy; clear_ovf_i = clr; rst_i = rs;
    if (rs) begin
      exp_q.delete();
      mdl_ovf = 1'b0; mdl_drop = 0;
    end else begin
      full = (exp_q.size() == DEPTH);
      rd   = (exp_q.size() != 0) && rdy;
      drop = v && full && !rd;
      if (rd) void'(exp_q.pop_front());
      if (v && (!full || rd)) exp_q.push_back({l, r});
      if (drop) begin
        mdl_ovf = 1'b1;
        mdl_drop = clr ? 1 : ((mdl_drop == 65535) ? 65535 : mdl_drop + 1);
      end else if (clr) begin
        mdl_ovf = 1'b0; mdl_drop = 0;
      end
    end
    @(posedge clk);
    #1;
    check("valid", 64'(out_valid_o), 64'(exp_q.size() != 0));
    check("level", 64'(level_o), 64'(exp_q.size()));
    check("overflow", 64'(overflow_o), 64'(mdl_ovf));
    check("drop_cnt", 64'(drop_cnt_o), 64'(mdl_drop));
    check("level_hi", 64'(level_hi_o), 64'(WM_EN && (exp_q.size() >= WM)));
    if (exp_q.size() != 0) check("head", 64'({out_left_o, out_right_o}), 64'(exp_q[0]));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit v; logic [23:0] l; logic [23:0] r; bit rdy; bit clr; bit rs;
    bit e_valid; bit e_chk_data; logic [23:0] e_l; logic [23:0] e_r;
    int e_level; bit e_ovf; int e_drop;
  } vec_t;
  vec_t vecs[7];

  initial begin
    //         v  l           r           rdy clr rs  val chk  e_l         e_r         lvl ovf drp
    vecs[0] = '{0, 24'h0,      24'h0,      0,  0,  1,  0,  1,   24'h0,      24'h0,      0,  0,  0};
    vecs[1] = '{1, 24'h7FFFFF, 24'h800000, 0,  0,  0,  1,  1,   24'h7FFFFF, 24'h800000, 1,  0,  0};
    vecs[2] = '{0, 24'h0,      24'h0,      1,  0,  0,  0,  0,   24'h0,      24'h0,      0,  0,  0};
    vecs[3] = '{1, 24'h123456, 24'hABCDEF, 1,  0,  0,  1,  1,   24'h123456, 24'hABCDEF, 1,  0,  0};
    vecs[4] = '{1, 24'h000001, 24'hFFFFFF, 1,  0,  0,  1,  1,   24'h000001, 24'hFFFFFF, 1,  0,  0};
    vecs[5] = '{0, 24'h0,      24'h0,      1,  0,  0,  0,  0,   24'h0,      24'h0,      0,  0,  0};
    vecs[6] = '{0, 24'h0,      24'h0,      0,  1,  0,  0,  0,   24'h0,      24'h0,      0,  0,  0};

    for (int i = 0; i < 7; i++) begin
      step(vecs[i].v, vecs[i].l, vecs[i].r, vecs[i].rdy, vecs[i].clr, vecs[i].rs);
      check($sformatf("vec%0d_valid", i), 64'(out_valid_o), 64'(vecs[i].e_valid));
      check($sformatf("vec%0d_level", i), 64'(level_o), 64'(vecs[i].e_level));
      check($sformatf("vec%0d_ovf", i), 64'(overflow_o), 64'(vecs[i].e_ovf));
      check($sformatf("vec%0d_drop", i), 64'(drop_cnt_o), 64'(vecs[i].e_drop));
      if (vecs[i].e_chk_data) begin
        check($sformatf("vec%0d_left", i), 64'(out_left_o), 64'(vecs[i].e_l));
        check($sformatf("vec%0d_right", i), 64'(out_right_o), 64'(vecs[i].e_r));
      end
    end

    // Fill to full with L=i, R=-i while stalled; watermark edge at 11/12.
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 24'(i), 24'(-i), 0, 0, 0);
      if (i == 10) check("wm_at_11", 64'(level_hi_o), 64'(0));
      if (i == 11) check("wm_at_12", 64'(level_hi_o), 64'(WM_EN));
    end
    check("full_level", 64'(level_o), 64'(16));
    check("full_no_ovf", 64'(overflow_o), 64'(0));

    // Three writes into a full, stalled FIFO are dropped.
    for (int i = 0; i < 3; i++) step(1, 24'h0AAAAA, 24'h055555, 0, 0, 0);
    check("ovf_set", 64'(overflow_o), 64'(1));
    check("drop_3", 64'(drop_cnt_o), 64'(3));
    check("head_kept", 64'({out_left_o, out_right_o}), 64'(48'h0));
    step(0, 24'h0, 24'h0, 0, 1, 0);
    check("clr_ovf", 64'(overflow_o), 64'(0));
    check("clr_drop", 64'(drop_cnt_o), 64'(0));

    // Drop and clear in the same cycle: the drop wins.
    step(1, 24'h0BBBBB, 24'h0CCCCC, 0, 1, 0);
    check("drop_vs_clr_ovf", 64'(overflow_o), 64'(1));
    check("drop_vs_clr_cnt", 64'(drop_cnt_o), 64'(1));
    step(0, 24'h0, 24'h0, 0, 1, 0);

    // Full with simultaneous write and read: both accepted.
    step(1, 24'h000100, 24'hFFFF00, 1, 0, 0);
    check("bypass_level", 64'(level_o), 64'(16));
    check("bypass_drop", 64'(drop_cnt_o), 64'(0));
    check("bypass_head", 64'(out_left_o), 64'(1));
    for (int i = 0; i < 15; i++) step(0, 24'h0, 24'h0, 1, 0, 0);
    check("bypass_frame_last", 64'({out_left_o, out_right_o}), 64'(48'h000100_FFFF00));
    step(0, 24'h0, 24'h0, 1, 0, 0);
    check("drained", 64'(out_valid_o), 64'(0));

    // Streaming write+read for 40 cycles: pointers wrap, no loss.
    for (int i = 0; i < 40; i++) step(1, 24'(i * 7 + 3), 24'(~(i * 7 + 3)), 1, 0, 0);
    check("stream_level", 64'(level_o), 64'(1));
    step(0, 24'h0, 24'h0, 1, 0, 0);

    // Reset with 5 frames stored discards them; next frame stores normally.
    for (int i = 0; i < 5; i++) step(1, 24'(i + 50), 24'(i + 60), 0, 0, 0);
    check("pre_rst_level", 64'(level_o), 64'(5));
    step(0, 24'h0, 24'h0, 0, 0, 1);
    check("rst_level", 64'(level_o), 64'(0));
    check("rst_valid", 64'(out_valid_o), 64'(0));
    step(1, 24'h400000, 24'hC00000, 0, 0, 0);
    check("post_rst_frame", 64'({out_left_o, out_right_o}), 64'(48'h400000_C00000));
    step(0, 24'h0, 24'h0, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
